// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: accepts machine code over valid/ready and drives
// registered datapath strobes; loads/stores span MEM_LAT cycles. Optional retire counter: CTRL_SEQ_RETIRE_CNT_EN.
module ctrl_sequencer #(
  parameter int MCODEBITS = 9,
  parameter int OPW       = 3,
  parameter int ALUOPW    = 3,
  parameter int MEM_LAT   = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 instr_valid,
  input  logic [MCODEBITS-1:0] instr,
  output logic                 instr_ready,
  output logic                 WantZero,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 RegOpOrOther,
  output logic [ALUOPW-1:0]    ALUOp,
  output logic                 PCEn,
  output logic                 Busy,
  output logic                 Done
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]          retire_cnt
`endif
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  localparam logic [OPW-1:0] OP_OR     = OPW'(0);
  localparam logic [OPW-1:0] OP_FLIP   = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB    = OPW'(2);
  localparam logic [OPW-1:0] OP_BRANCH = OPW'(3);
  localparam logic [OPW-1:0] OP_MVI    = OPW'(4);
  localparam logic [OPW-1:0] OP_LOAD   = OPW'(5);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(6);

  localparam logic [ALUOPW-1:0] ALU_OR   = ALUOPW'(7);
  localparam logic [ALUOPW-1:0] ALU_FLIP = ALUOPW'(2);
  localparam logic [ALUOPW-1:0] ALU_SUB  = ALUOPW'(6);
  localparam logic [ALUOPW-1:0] ALU_ADD  = ALUOPW'(0);

  // A single-cycle memory latency never needs the wait state or its counter.
  localparam bit MULTI = (MEM_LAT > 1);
  localparam int CW    = MULTI ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(MULTI ? MEM_LAT - 2 : 0);

  typedef struct packed {
    logic              want_zero;
    logic              branch;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic              reg_op;
    logic [ALUOPW-1:0] alu_op;
    logic              pc_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NOOP = ctrl_t'({7'b0, {ALUOPW{1'b1}}, 1'b0});

  logic [1:0]     state_q, state_nx;
  logic [CW-1:0]  cnt_q, cnt_nx;
  ctrl_t          ctrl_q, ctrl_nx, dec;
  logic [OPW-1:0] opcode;
  logic           is_halt;
  logic           is_mem;

  assign opcode  = instr[MCODEBITS-1 -: OPW];
  assign is_halt = &instr;
  assign is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // Decoded controls for the first output cycle of the presented instruction.
  always_comb begin
    dec       = CTRL_NOOP;
    dec.pc_en = 1'b1;
    case (opcode)
      OP_OR:     begin dec.reg_write = 1'b1; dec.alu_op = ALU_OR;   end
      OP_FLIP:   begin dec.reg_write = 1'b1; dec.alu_op = ALU_FLIP; end
      OP_SUB:    begin dec.reg_write = 1'b1; dec.alu_op = ALU_SUB;  end
      OP_BRANCH: begin dec.branch    = 1'b1; dec.alu_op = ALU_ADD;  end
      OP_MVI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.want_zero = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_LOAD: begin
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = !MULTI;
        dec.pc_en      = !MULTI;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.pc_en     = !MULTI;
      end
      default: begin dec.reg_write = 1'b1; dec.reg_op = 1'b1; end
    endcase
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_nx = state_q;
    cnt_nx   = cnt_q;
    ctrl_nx  = CTRL_NOOP;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (instr_valid) begin
          if (is_halt) begin
            state_nx = S_HALT;
          end else begin
            ctrl_nx = dec;
            if (MULTI && is_mem) begin
              state_nx = S_MEM_WAIT;
              cnt_nx   = WAIT_INIT;
            end
          end
        end
      end
      S_MEM_WAIT: begin
        // Hold the memory strobes; write-back and PC advance land on the last cycle.
        ctrl_nx           = ctrl_q;
        ctrl_nx.pc_en     = (cnt_q == '0);
        ctrl_nx.reg_write = (cnt_q == '0) && ctrl_q.mem_to_reg;
        if (cnt_q == '0) state_nx = S_EXEC;
        else             cnt_nx   = cnt_q - CW'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_NOOP;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      ctrl_q  <= ctrl_nx;
    end
  end

  assign instr_ready  = (state_q == S_EXEC);
  assign Busy         = (state_q == S_EXEC) || (state_q == S_MEM_WAIT);
  assign Done         = (state_q == S_HALT);
  assign WantZero     = ctrl_q.want_zero;
  assign Branch       = ctrl_q.branch;
  assign MemtoReg     = ctrl_q.mem_to_reg;
  assign MemWrite     = ctrl_q.mem_write;
  assign ALUSrc       = ctrl_q.alu_src;
  assign RegWrite     = ctrl_q.reg_write;
  assign RegOpOrOther = ctrl_q.reg_op;
  assign ALUOp        = ctrl_q.alu_op;
  assign PCEn         = ctrl_q.pc_en;

`ifdef CTRL_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                  retire_q <= '0;
    else if (Busy && ctrl_q.pc_en) retire_q <= retire_q + 16'd1;
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: two instances (MEM_LAT=3 and MEM_LAT=1) share
// randomized stimulus and are checked against a queue-based instruction-level model.
module tb_ctrl_sequencer;

  localparam int NDUT = 2;
  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  typedef struct packed {
    logic        ready, wz, br, m2r, mw, asrc, rw, rop;
    logic [2:0]  aluop;
    logic        pcen, busy, done;
    logic [15:0] rcnt;
  } rec_t;

  typedef enum int {M_IDLE, M_RUN, M_HALT} mode_e;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = '0;

  logic       rdy [NDUT], wz [NDUT], br [NDUT], m2r [NDUT], mw [NDUT];
  logic       asrc [NDUT], rw [NDUT], rop [NDUT], pcen [NDUT], busy [NDUT], done [NDUT];
  logic [2:0] aop [NDUT];
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  logic [15:0] rc [NDUT];
`endif

  always #5 Clk = ~Clk;

  ctrl_sequencer #(.MCODEBITS(9), .OPW(3), .ALUOPW(3), .MEM_LAT(LAT0)) dut0 (
    .Clk(Clk), .Reset(Reset), .start(start), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(rdy[0]), .WantZero(wz[0]), .Branch(br[0]), .MemtoReg(m2r[0]),
    .MemWrite(mw[0]), .ALUSrc(asrc[0]), .RegWrite(rw[0]), .RegOpOrOther(rop[0]),
    .ALUOp(aop[0]), .PCEn(pcen[0]), .Busy(busy[0]), .Done(done[0])
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    , .retire_cnt(rc[0])
`endif
  );

  ctrl_sequencer #(.MCODEBITS(9), .OPW(3), .ALUOPW(3), .MEM_LAT(LAT1)) dut1 (
    .Clk(Clk), .Reset(Reset), .start(start), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(rdy[1]), .WantZero(wz[1]), .Branch(br[1]), .MemtoReg(m2r[1]),
    .MemWrite(mw[1]), .ALUSrc(asrc[1]), .RegWrite(rw[1]), .RegOpOrOther(rop[1]),
    .ALUOp(aop[1]), .PCEn(pcen[1]), .Busy(busy[1]), .Done(done[1])
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    , .retire_cnt(rc[1])
`endif
  );

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  rec_t  exp_q [NDUT][$];
  rec_t  plan_q [NDUT][$];
  mode_e mode [NDUT];
  logic [15:0] ret [NDUT];
  int    lat [NDUT];

  always @(posedge Clk) cyc++;

  function automatic rec_t noop_rec();
    rec_t r;
    r = '0;
    r.aluop = 3'b111;
    return r;
  endfunction

  function automatic rec_t get_act(int i);
    rec_t a;
    a.ready = rdy[i]; a.wz = wz[i]; a.br = br[i]; a.m2r = m2r[i]; a.mw = mw[i];
    a.asrc = asrc[i]; a.rw = rw[i]; a.rop = rop[i]; a.aluop = aop[i];
    a.pcen = pcen[i]; a.busy = busy[i]; a.done = done[i];
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    a.rcnt = rc[i];
`else
    a.rcnt = '0;
`endif
    return a;
  endfunction

  task automatic check(input string name, input int i, input rec_t got, input rec_t exp);
    n_vec++;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    if (got !== exp) begin
`else
    if (got[$bits(rec_t)-1:16] !== exp[$bits(rec_t)-1:16]) begin
`endif
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, i, cyc, got, exp);
    end
  endtask

  // Instruction-level reference: each accepted instruction expands into its list of
  // output cycles; the sequencer is ready only when no planned cycles remain.
  task automatic model_step(input int i, input bit s, input bit v, input logic [8:0] ins);
    rec_t r, d;
    int n;
    r = noop_rec();
    if (mode[i] == M_RUN) begin
      if (plan_q[i].size() > 0) begin
        r = plan_q[i].pop_front();
      end else if (v) begin
        if (ins == 9'h1FF) begin
          mode[i] = M_HALT;
        end else begin
          d = noop_rec();
          case (ins[8:6])
            3'd0: begin d.rw = 1; d.aluop = 3'b111; end
            3'd1: begin d.rw = 1; d.aluop = 3'b010; end
            3'd2: begin d.rw = 1; d.aluop = 3'b110; end
            3'd3: begin d.br = 1; d.aluop = 3'b000; end
            3'd4: begin d.rw = 1; d.asrc = 1; d.wz = 1; d.aluop = 3'b000; end
            3'd5: d.m2r = 1;
            3'd6: d.mw = 1;
            default: begin d.rw = 1; d.rop = 1; end
          endcase
          n = (ins[8:6] == 3'd5 || ins[8:6] == 3'd6) ? lat[i] : 1;
          for (int j = 0; j < n; j++) begin
            rec_t p;
            p = d;
            p.pcen = (j == n - 1);
            if (ins[8:6] == 3'd5) p.rw = (j == n - 1);
            plan_q[i].push_back(p);
          end
          r = plan_q[i].pop_front();
        end
      end
    end else if (s) begin
      mode[i] = M_RUN;
    end
    r.ready = (mode[i] == M_RUN) && (plan_q[i].size() == 0);
    r.busy  = (mode[i] == M_RUN);
    r.done  = (mode[i] == M_HALT);
    r.rcnt  = ret[i];
    ret[i]  = ret[i] + 16'(r.pcen);
    exp_q[i].push_back(r);
  endtask

  // Called at posedge+1: drive this cycle's inputs, predict next cycle, advance.
  task automatic step(input bit s, input bit v, input logic [8:0] ins);
    start = s;
    instr_valid = v;
    instr = ins;
    for (int i = 0; i < NDUT; i++) model_step(i, s, v, ins);
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      mode[i] = M_IDLE;
      ret[i]  = '0;
      plan_q[i].delete();
      exp_q[i].delete();
      exp_q[i].push_back(noop_rec());
    end
  endtask

  task automatic release_reset();
    Reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  // Asserted mid-cycle to show that clearing does not wait for a clock edge.
  task automatic reset_mid_cycle();
    start = 1'b0;
    instr_valid = 1'b0;
    #3;
    Reset = 1'b1;
    mon_en = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) check("async_reset", i, get_act(i), noop_rec());
    repeat (2) @(posedge Clk);
    #1;
    release_reset();
  endtask

  function automatic logic [8:0] rand_instr();
    logic [8:0] x;
    x = 9'($urandom);
    if ($urandom_range(0, 15) == 0) x = 9'h1FF;
    return x;
  endfunction

  task automatic random_run(input int cycles);
    for (int k = 0; k < cycles; k++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, rand_instr());
  endtask

  always @(negedge Clk) begin
    rec_t e;
    if (mon_en && !Reset) begin
      for (int i = 0; i < NDUT; i++) begin
        if (exp_q[i].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard dut%0d cycle %0d: no expected entry", i, cyc);
        end else begin
          e = exp_q[i].pop_front();
          check("outputs", i, get_act(i), e);
        end
      end
    end
  end

  initial begin
    lat[0] = LAT0;
    lat[1] = LAT1;
    repeat (2) @(posedge Clk);
    #1;
    release_reset();

    step(1, 0, '0);
    step(0, 1, 9'b010_000001);
    step(0, 1, 9'b100_000101);
    step(0, 1, 9'b011_000000);
    step(0, 0, '0);

    step(0, 1, 9'b101_000010);
    step(0, 0, 9'b000_111111);
    step(0, 0, 9'b111_000000);
    step(0, 0, '0);
    repeat (3) step(0, 1, 9'b110_000011);
    repeat (3) step(0, 0, '0);

    step(0, 1, 9'h1FF);
    repeat (10) step(0, 1, rand_instr());
    step(1, 0, '0);
    step(0, 1, 9'b111_010101);
    step(0, 0, '0);

    random_run(400);

    step(1, 0, '0);
    step(0, 1, 9'b101_000001);
    reset_mid_cycle();
    step(1, 0, '0);
    random_run(400);

    step(1, 0, '0);
    step(0, 1, 9'h1FF);
    repeat (4) step(0, 0, '0);
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
